// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider.
//   - div_state_e     : FSM state encodings (IDLE, DIVZERO, ON, DONE)
//   - DivStart/DivStop, DivResultReady/DivResultNotReady : handshake levels
//   - `DIV_RESULT(rem, quo) : packs the result bus, remainder in the high half,
//                             quotient in the low half
`ifndef DIV_PKG_SV
`define DIV_PKG_SV

`define DIV_RESULT(rem, quo) {(rem), (quo)}

package div_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      DIVZERO = 2'b01,
      ON      = 2'b10,
      DONE    = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

endpackage

`endif

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration.
// Ports:
//   rem_i     [WIDTH:0]   partial remainder from the previous iteration
//   divisor_i [WIDTH-1:0] divisor magnitude
//   dvd_bit_i             next dividend bit (MSB first)
//   rem_o     [WIDTH:0]   new partial remainder
//   q_bit_o               quotient bit produced by this iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             dvd_bit_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH:0]   w_diff;

   assign w_shift = {rem_i, dvd_bit_i};
   assign q_bit_o = (w_shift >= {2'b00, divisor_i});
   // Only taken when the trial is non-negative, so the result always fits
   // in WIDTH+1 bits and the modular subtraction is exact.
   assign w_diff  = w_shift[WIDTH:0] - {1'b0, divisor_i};
   assign rem_o   = q_bit_o ? w_diff : w_shift[WIDTH:0];

endmodule

// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle radix-2 restoring integer divider (signed or
// unsigned) with divide-by-zero flag, busy indication and annul.
// Optional build macro: DIV_EARLY_OUT_EN -- when defined, a nonzero divisor
// larger than the dividend magnitude finishes directly at accept.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start_i               divide request (level), accepted only in IDLE
//   signed_i              1 = two's-complement operands, sampled at accept
//   annul_i               abort; blocks accept in IDLE
//   opdata1_i, opdata2_i  dividend / divisor, sampled at accept
//   busy_o                high whenever not IDLE
//   ready_o               one-cycle pulse, result_o valid
//   dbz_o                 divisor was zero, held with result_o
//   result_o              {remainder, quotient}, held until replaced
//
// state   | meaning
// IDLE    | waiting for an accept
// DIVZERO | zero divisor, stage result 0 and flag
// ON      | one restoring iteration per cycle
// DONE    | ready_o pulse, result valid
module iter_div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic                 annul_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic                 dbz_o,
   output logic [2*WIDTH-1:0]   result_o
);

   localparam int CNT_W = $clog2(WIDTH+1);
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH-1);

   div_state_e         r_state;
   div_state_e         w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dvs;
   logic               r_q_neg;
   logic               r_r_neg;
   logic [2*WIDTH-1:0] r_result;
   logic               r_dbz;

   logic               w_accept;
   logic               w_dvs_zero;
   logic               w_early;
   logic               w_last;
   logic               w_q_bit;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [WIDTH:0]     w_rem_next;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_accept   = (start_i == DivStart) && !annul_i;
   assign w_dvs_zero = (opdata2_i == '0);
   // Negating the most negative value yields the same bit pattern, which read
   // as unsigned is exactly its magnitude.
   assign w_mag1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign w_mag2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
   assign w_early = !w_dvs_zero && (w_mag1 < w_mag2);
`else
   assign w_early = 1'b0;
`endif

   assign w_last = (r_cnt == LastCnt);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (r_rem),
      .divisor_i (r_dvs),
      .dvd_bit_i (r_dvd[WIDTH-1]),
      .rem_o     (w_rem_next),
      .q_bit_o   (w_q_bit)
   );

   // r_dvd shifts dividend bits out of the top and quotient bits in at the
   // bottom, so after WIDTH iterations it holds the quotient magnitude.
   assign w_quo     = {r_dvd[WIDTH-2:0], w_q_bit};
   assign w_quo_fix = r_q_neg ? -w_quo : w_quo;
   assign w_rem_fix = r_r_neg ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_dvs_zero)   w_next_state = DIVZERO;
               else if (w_early) w_next_state = DONE;
               else              w_next_state = ON;
            end
         end
         DIVZERO: w_next_state = annul_i ? IDLE : DONE;
         ON: begin
            if (annul_i)     w_next_state = IDLE;
            else if (w_last) w_next_state = DONE;
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_q_neg  <= 1'b0;
         r_r_neg  <= 1'b0;
         r_result <= '0;
         r_dbz    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_dvd   <= w_mag1;
                  r_dvs   <= w_mag2;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_q_neg <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  r_r_neg <= signed_i & opdata1_i[WIDTH-1];
                  if (w_early) begin
                     r_result <= `DIV_RESULT(opdata1_i, {WIDTH{1'b0}});
                     r_dbz    <= 1'b0;
                  end
               end
            end
            DIVZERO: begin
               if (!annul_i) begin
                  r_result <= '0;
                  r_dbz    <= 1'b1;
               end
            end
            ON: begin
               r_rem <= w_rem_next;
               r_dvd <= w_quo;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last && !annul_i) begin
                  r_result <= `DIV_RESULT(w_rem_fix, w_quo_fix);
                  r_dbz    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o   = (r_state != IDLE);
   assign ready_o  = (r_state == DONE) ? DivResultReady : DivResultNotReady;
   assign dbz_o    = r_dbz;
   assign result_o = r_result;

endmodule

// File: tb/tb_iter_div_unit.sv
// tb_iter_div_unit: directed, table-driven bench for iter_div_unit (WIDTH=32),
// plus hand-written sequences for annul, reset and zero-divisor corners.
// Honours DIV_EARLY_OUT_EN for the expected latency of small-dividend cases.
module tb_iter_div_unit;
   import div_pkg::*;

   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_EO = 1;
`else
   localparam int LAT_EO = W+1;
`endif
   localparam int LAT_N = W+1;
   localparam int LAT_Z = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           start_i;
   logic           signed_i;
   logic           annul_i;
   logic [W-1:0]   opdata1_i;
   logic [W-1:0]   opdata2_i;
   logic           busy_o;
   logic           ready_o;
   logic           dbz_o;
   logic [2*W-1:0] result_o;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] last_res;
   logic           last_dbz;

   always #5 clk = ~clk;

   iter_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .signed_i  (signed_i),
      .annul_i   (annul_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .busy_o    (busy_o),
      .ready_o   (ready_o),
      .dbz_o     (dbz_o),
      .result_o  (result_o)
   );

   typedef struct {
      string      name;
      logic       sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic       dbz;
      int         lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      signed_i  = v.sgn;
      opdata1_i = v.a;
      opdata2_i = v.b;
      annul_i   = 1'b0;
      start_i   = DivStart;
      @(posedge clk);
      lat     = 0;
      busy_ok = 1'b1;
      for (int c = 1; c <= 200 && lat == 0; c++) begin
         @(negedge clk);
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         signed_i  = ~v.sgn;
         if (ready_o) begin
            lat     = c;
            start_i = DivStop;
         end else if (!busy_o) begin
            busy_ok = 1'b0;
         end
      end
      check({v.name, "_lat"}, 64'(lat), 64'(v.lat));
      check({v.name, "_busy"}, 64'(busy_ok), 64'd1);
      check({v.name, "_quo"}, 64'(result_o[W-1:0]), 64'(v.q));
      check({v.name, "_rem"}, 64'(result_o[2*W-1:W]), 64'(v.r));
      check({v.name, "_dbz"}, 64'(dbz_o), 64'(v.dbz));
      @(negedge clk);
      check({v.name, "_idle"}, 64'({ready_o, busy_o}), 64'd0);
      check({v.name, "_hold"}, result_o, {v.r, v.q});
      last_res = {v.r, v.q};
      last_dbz = v.dbz;
   endtask

   initial begin
      vecs[0]  = '{"u100_7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, LAT_N};
      vecs[1]  = '{"s_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, LAT_N};
      vecs[2]  = '{"s7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, LAT_N};
      vecs[3]  = '{"s_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, LAT_N};
      vecs[4]  = '{"u_min_max",  1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, LAT_EO};
      vecs[5]  = '{"u_dbz",      1'b0, 32'h1234,       32'd0,          32'd0,          32'd0,          1'b1, LAT_Z};
      vecs[6]  = '{"u9_3",       1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, LAT_N};
      vecs[7]  = '{"u5_9",       1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, LAT_EO};
      vecs[8]  = '{"s_m5_9",     1'b1, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB,   1'b0, LAT_EO};
      vecs[9]  = '{"u_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, LAT_N};
      vecs[10] = '{"s100_m7",    1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, LAT_N};
      vecs[11] = '{"s_m100_m7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, LAT_N};
      vecs[12] = '{"s_dbz_min",  1'b1, 32'h80000000,   32'd0,          32'd0,          32'd0,          1'b1, LAT_Z};
      vecs[13] = '{"u0_5",       1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, LAT_EO};
      vecs[14] = '{"u_max_max",  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, LAT_N};
      vecs[15] = '{"s_min_2",    1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0, LAT_N};

      rst       = 1'b1;
      start_i   = DivStop;
      signed_i  = 1'b0;
      annul_i   = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (3) @(negedge clk);
      check("reset_busy_ready_dbz", 64'({busy_o, ready_o, dbz_o}), 64'd0);
      check("reset_result", result_o, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) run_op(vecs[i]);

      // annul in IDLE blocks the accept
      begin
         logic busy_seen;
         busy_seen = 1'b0;
         @(negedge clk);
         start_i = DivStart;
         annul_i = 1'b1;
         repeat (3) begin
            @(negedge clk);
            busy_seen = busy_seen | busy_o;
         end
         start_i = DivStop;
         annul_i = 1'b0;
         check("annul_idle_busy", 64'(busy_seen), 64'd0);
      end

      // annul in cycle 10 of 1000/3: idle in cycle 11, no ready, result held
      begin
         logic rdy_seen;
         rdy_seen = 1'b0;
         @(negedge clk);
         signed_i  = 1'b0;
         opdata1_i = 32'd1000;
         opdata2_i = 32'd3;
         start_i   = DivStart;
         @(posedge clk);
         repeat (10) @(negedge clk);
         annul_i = 1'b1;
         start_i = DivStop;
         @(negedge clk);
         check("annul_on_idle", 64'(busy_o), 64'd0);
         annul_i = 1'b0;
         repeat (40) begin
            @(negedge clk);
            rdy_seen = rdy_seen | ready_o;
         end
         check("annul_on_noready", 64'(rdy_seen), 64'd0);
         check("annul_on_result", result_o, last_res);
         check("annul_on_dbz", 64'(dbz_o), 64'(last_dbz));
      end
      run_op('{"after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT_N});

      // annul during DIVZERO: no ready, flag and result untouched
      begin
         @(negedge clk);
         signed_i  = 1'b0;
         opdata1_i = 32'h1234;
         opdata2_i = 32'd0;
         start_i   = DivStart;
         @(posedge clk);
         @(negedge clk);
         annul_i = 1'b1;
         start_i = DivStop;
         @(negedge clk);
         annul_i = 1'b0;
         check("annul_dz_state", 64'({busy_o, ready_o}), 64'd0);
         check("annul_dz_dbz", 64'(dbz_o), 64'd0);
         check("annul_dz_result", result_o, last_res);
      end

      // reset mid-operation clears result and returns to idle
      begin
         @(negedge clk);
         signed_i  = 1'b0;
         opdata1_i = 32'd100;
         opdata2_i = 32'd7;
         start_i   = DivStart;
         @(posedge clk);
         repeat (5) @(negedge clk);
         start_i = DivStop;
         rst     = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("midrst_busy", 64'(busy_o), 64'd0);
         check("midrst_result", result_o, 64'd0);
         check("midrst_dbz", 64'(dbz_o), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
